// File: rtl/clock_mux_sel_ctrl.sv
// Select-bus sequencer for clock_mux_synth: validates switch requests and runs
// gate-off / switch / settle / gate-on so the select only moves while the gate is closed.
module clock_mux_sel_ctrl #(
  parameter int NUM_CLOCKS    = 4,
  parameter int NUM_CLOCK_SEL = 2,
  parameter int GATE_WAIT     = 8,
  parameter int SETTLE_WAIT   = 16,
  parameter int RESET_SEL     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel_req,
  input  logic [NUM_CLOCK_SEL-1:0] sel_req_id,
  input  logic [NUM_CLOCKS-1:0]    clk_valid,
  output logic [NUM_CLOCK_SEL-1:0] clk_sel,
  output logic                     clk_gate_en,
  output logic                     busy,
  output logic                     sel_ack,
  output logic                     sel_err
);

  localparam int MAX_WAIT = (GATE_WAIT > SETTLE_WAIT) ? GATE_WAIT : SETTLE_WAIT;
  localparam int CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int PADW     = 1 << NUM_CLOCK_SEL;

  localparam logic [CW-1:0]            GATE_LOAD   = CW'(GATE_WAIT - 1);
  localparam logic [CW-1:0]            SETTLE_LOAD = CW'(SETTLE_WAIT - 1);
  localparam logic [NUM_CLOCK_SEL-1:0] RST_SEL     = NUM_CLOCK_SEL'(RESET_SEL);

  typedef enum logic [1:0] {
    IDLE,
    GATE_OFF,
    SETTLE,
    GATE_ON
  } state_t;

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [NUM_CLOCK_SEL-1:0] target, target_n;
  logic [NUM_CLOCK_SEL-1:0] prev_sel, prev_sel_n;
  logic                     aborted, aborted_n;
  logic                     boot, boot_n;
  logic [NUM_CLOCK_SEL-1:0] clk_sel_n;
  logic                     clk_gate_en_n, busy_n, sel_ack_n, sel_err_n;

  // Status padded to the full select range so out-of-range ids read as invalid.
  logic [PADW-1:0] valid_pad;
  logic            req_ok;
  logic            target_lost;

  always_comb begin
    valid_pad                 = '0;
    valid_pad[NUM_CLOCKS-1:0] = clk_valid;
  end

  assign req_ok      = (32'(sel_req_id) < NUM_CLOCKS) && valid_pad[sel_req_id];
  // The boot sequence and an already-aborted sequence never abort again.
  assign target_lost = !aborted && !boot && !valid_pad[target];

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    target_n      = target;
    prev_sel_n    = prev_sel;
    aborted_n     = aborted;
    boot_n        = boot;
    clk_sel_n     = clk_sel;
    clk_gate_en_n = clk_gate_en;
    busy_n        = busy;
    sel_ack_n     = 1'b0;
    sel_err_n     = 1'b0;

    unique case (state)
      IDLE: begin
        if (sel_req) begin
          if (!req_ok) begin
            sel_err_n = 1'b1;
          end else if (sel_req_id == clk_sel) begin
            sel_ack_n = 1'b1;
          end else begin
            target_n      = sel_req_id;
            prev_sel_n    = clk_sel;
            aborted_n     = 1'b0;
            clk_gate_en_n = 1'b0;
            busy_n        = 1'b1;
            cnt_n         = GATE_LOAD;
            state_n       = GATE_OFF;
          end
        end
      end

      GATE_OFF, SETTLE: begin
        if (target_lost) begin
          // Fall back to the previous source and give it a full settle period.
          clk_sel_n = prev_sel;
          target_n  = prev_sel;
          aborted_n = 1'b1;
          cnt_n     = SETTLE_LOAD;
          state_n   = SETTLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (state == GATE_OFF) begin
          clk_sel_n = target;
          cnt_n     = SETTLE_LOAD;
          state_n   = SETTLE;
        end else begin
          clk_gate_en_n = 1'b1;
          busy_n        = 1'b0;
          sel_ack_n     = !boot && !aborted;
          sel_err_n     = !boot && aborted;
          state_n       = GATE_ON;
        end
      end

      GATE_ON: begin
        boot_n    = 1'b0;
        aborted_n = 1'b0;
        state_n   = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SETTLE;
      cnt         <= SETTLE_LOAD;
      target      <= RST_SEL;
      prev_sel    <= RST_SEL;
      aborted     <= 1'b0;
      boot        <= 1'b1;
      clk_sel     <= RST_SEL;
      clk_gate_en <= 1'b0;
      busy        <= 1'b1;
      sel_ack     <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      target      <= target_n;
      prev_sel    <= prev_sel_n;
      aborted     <= aborted_n;
      boot        <= boot_n;
      clk_sel     <= clk_sel_n;
      clk_gate_en <= clk_gate_en_n;
      busy        <= busy_n;
      sel_ack     <= sel_ack_n;
      sel_err     <= sel_err_n;
    end
  end

endmodule

// File: tb/tb_clock_mux_sel_ctrl.sv
// Directed bench for clock_mux_sel_ctrl: request table plus timed switch, abort and reset sequences.
module tb_clock_mux_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel_req = 1'b0;
  logic [1:0] sel_req_id = '0;
  logic [3:0] clk_valid = 4'b1111;

  logic [1:0] clk_sel, clk_sel3;
  logic       clk_gate_en, busy, sel_ack, sel_err;
  logic       clk_gate_en3, busy3, sel_ack3, sel_err3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clock_mux_sel_ctrl #(
    .NUM_CLOCKS(4), .NUM_CLOCK_SEL(2), .GATE_WAIT(4), .SETTLE_WAIT(8), .RESET_SEL(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_req_id(sel_req_id),
    .clk_valid(clk_valid), .clk_sel(clk_sel), .clk_gate_en(clk_gate_en),
    .busy(busy), .sel_ack(sel_ack), .sel_err(sel_err)
  );

  clock_mux_sel_ctrl #(
    .NUM_CLOCKS(3), .NUM_CLOCK_SEL(2), .GATE_WAIT(4), .SETTLE_WAIT(8), .RESET_SEL(0)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_req_id(sel_req_id),
    .clk_valid(clk_valid[2:0]), .clk_sel(clk_sel3), .clk_gate_en(clk_gate_en3),
    .busy(busy3), .sel_ack(sel_ack3), .sel_err(sel_err3)
  );

  typedef struct {
    logic [1:0] id;
    logic [3:0] valid;
    logic       sw;
    logic       exp_ack;
    logic       exp_err;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string nm, input logic [1:0] s, input logic g,
                          input logic b, input logic a, input logic e);
    chk({nm, ".clk_sel"}, 32'(clk_sel), 32'(s));
    chk({nm, ".gate_en"}, 32'(clk_gate_en), 32'(g));
    chk({nm, ".busy"}, 32'(busy), 32'(b));
    chk({nm, ".ack"}, 32'(sel_ack), 32'(a));
    chk({nm, ".err"}, 32'(sel_err), 32'(e));
  endtask

  // Hold reset for three edges, release, and expect the gate to open 8 edges later.
  task automatic do_reset();
    rst_n = 1'b0;
    sel_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_outs("rst_hold", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 8) chk_outs("boot_settle", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      else       chk_outs("boot_open", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step();
    chk_outs("boot_idle", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{id: 2'd2, valid: 4'b1111, sw: 1'b0, exp_ack: 1'b1, exp_err: 1'b0, exp_sel: 2'd2};
    vecs[1] = '{id: 2'd3, valid: 4'b0111, sw: 1'b0, exp_ack: 1'b0, exp_err: 1'b1, exp_sel: 2'd2};
    vecs[2] = '{id: 2'd1, valid: 4'b1101, sw: 1'b0, exp_ack: 1'b0, exp_err: 1'b1, exp_sel: 2'd2};
    vecs[3] = '{id: 2'd0, valid: 4'b1111, sw: 1'b1, exp_ack: 1'b0, exp_err: 1'b0, exp_sel: 2'd2};
    vecs[4] = '{id: 2'd0, valid: 4'b1111, sw: 1'b0, exp_ack: 1'b1, exp_err: 1'b0, exp_sel: 2'd0};
    vecs[5] = '{id: 2'd2, valid: 4'b1011, sw: 1'b0, exp_ack: 1'b0, exp_err: 1'b1, exp_sel: 2'd0};

    // Power-up reset and boot sequence.
    do_reset();

    // Same-source request right after boot.
    sel_req = 1'b1; sel_req_id = 2'd0; clk_valid = 4'b1111;
    step();
    sel_req = 1'b0;
    chk_outs("same_src0", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Timed switch 0->2 with a dropped request at T+6.
    sel_req = 1'b1; sel_req_id = 2'd2;
    step();
    sel_req = 1'b0;
    chk_outs("sw_t1", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k <= 13; k++) begin
      step();
      if (k == 6) begin
        sel_req = 1'b1; sel_req_id = 2'd1;
      end else begin
        sel_req = 1'b0;
      end
      if (k == 4)  chk_outs("sw_t4", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 5)  chk_outs("sw_t5", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 12) chk_outs("sw_t12", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 13) chk_outs("sw_t13", 2'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      if (k > 5 && k < 13) chk("busy_no_resp", 32'({sel_ack, sel_err}), 32'd0);
    end
    step();
    chk_outs("sw_t14", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Request table applied from clk_sel=2.
    for (int v = 0; v < 6; v++) begin
      bit done;
      sel_req = 1'b1; sel_req_id = vecs[v].id; clk_valid = vecs[v].valid;
      step();
      sel_req = 1'b0;
      chk(  $sformatf("vec%0d.ack", v), 32'(sel_ack), 32'(vecs[v].exp_ack));
      chk(  $sformatf("vec%0d.err", v), 32'(sel_err), 32'(vecs[v].exp_err));
      chk(  $sformatf("vec%0d.sel", v), 32'(clk_sel), 32'(vecs[v].exp_sel));
      chk(  $sformatf("vec%0d.gate", v), 32'(clk_gate_en), 32'(!vecs[v].sw));
      chk(  $sformatf("vec%0d.busy", v), 32'(busy), 32'(vecs[v].sw));
      if (vecs[v].sw) begin
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
          step();
          if (clk_gate_en === 1'b1) done = 1'b1;
        end
        chk($sformatf("vec%0d.finish", v), 32'(done), 32'd1);
        chk($sformatf("vec%0d.final_ack", v), 32'(sel_ack), 32'd1);
        chk($sformatf("vec%0d.final_sel", v), 32'(clk_sel), 32'(vecs[v].id));
        step();
      end
    end

    // Abort: switch 0->2, target clock drops in T+7.
    clk_valid = 4'b1111;
    sel_req = 1'b1; sel_req_id = 2'd2;
    for (int k = 1; k <= 16; k++) begin
      step();
      sel_req = 1'b0;
      if (k == 7) clk_valid = 4'b1011;
      if (k == 9) clk_valid = 4'b1111;
      if (k == 5)  chk_outs("abort_t5", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 7)  chk_outs("abort_t7", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 8)  chk_outs("abort_t8", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 15) chk_outs("abort_t15", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 16) chk_outs("abort_t16", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      if (k < 16) chk("abort_no_ack", 32'(sel_ack), 32'd0);
    end
    step();
    chk_outs("abort_idle", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // id=3: out of range for the 3-clock build, a real switch for the 4-clock build,
    // which is then hit by reset at T+3.
    sel_req = 1'b1; sel_req_id = 2'd3; clk_valid = 4'b1111;
    step();
    sel_req = 1'b0;
    chk("nc3_err", 32'(sel_err3), 32'd1);
    chk("nc3_ack", 32'(sel_ack3), 32'd0);
    chk("nc3_sel", 32'(clk_sel3), 32'd0);
    chk("nc3_gate", 32'(clk_gate_en3), 32'd1);
    chk_outs("mid_t1", 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clock_mux_sel_ctrl.md
Name: clock_mux_sel_ctrl

Overview:
Sequencer that owns the select bus of clock_mux_synth. It accepts clock-switch requests over a pulse handshake, validates them against per-source clock status, and runs a gate-off / switch / settle / gate-on sequence so the downstream clock gate is closed whenever the mux select changes. It runs on an always-on reference clock and sits beside the mux in each clock-generation cluster.

Parameters:
NUM_CLOCKS, 4, number of mux inputs; legal range 2..8.
NUM_CLOCK_SEL, 2, select width; must equal clog2(NUM_CLOCKS).
GATE_WAIT, 8, cycles the gate stays off before the select changes; must be >= 1.
SETTLE_WAIT, 16, cycles after a select change before the gate reopens; must be >= 1.
RESET_SEL, 0, select value applied in reset; must be < NUM_CLOCKS.

Ports:
clk  input  1  always-on reference clock
rst_n  input  1  reset
sel_req  input  1  single-cycle switch request pulse
sel_req_id  input  NUM_CLOCK_SEL  requested source index, sampled with sel_req
clk_valid  input  NUM_CLOCKS  per-source "running and stable" status, already synchronous to clk
clk_sel  output  NUM_CLOCK_SEL  registered select to clock_mux_synth
clk_gate_en  output  1  registered enable to the downstream clock gate
busy  output  1  high while a sequence is in progress; requests are ignored
sel_ack  output  1  one-cycle pulse: request completed successfully
sel_err  output  1  one-cycle pulse: request rejected or aborted

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values, including any assertion of rst_n mid-sequence: clk_sel=RESET_SEL, clk_gate_en=0, busy=1, sel_ack=0, sel_err=0. The state is SETTLE with counter=SETTLE_WAIT-1 and prev_sel=RESET_SEL.
- States: IDLE, GATE_OFF, SETTLE, GATE_ON. A single down-counter is sized to the maximum of GATE_WAIT and SETTLE_WAIT.
- Post-reset: SETTLE counts down. clk_gate_en=1 and busy=0 take effect SETTLE_WAIT cycles after the first edge that samples rst_n=1. No sel_ack is issued for the reset sequence.
- IDLE (busy=0): when sel_req=1 in cycle T, one of three outcomes applies, with the response visible in T+1:
  - sel_req_id >= NUM_CLOCKS, or clk_valid[sel_req_id]=0: sel_err=1 for one cycle. No other change.
  - sel_req_id == clk_sel: sel_ack=1 for one cycle. clk_gate_en stays 1.
  - Otherwise: latch target=sel_req_id and prev_sel=clk_sel, drive clk_gate_en=0 and busy=1, and enter GATE_OFF with counter=GATE_WAIT-1.
- GATE_OFF: occupies T+1..T+GATE_WAIT. When counter=0, the next cycle enters SETTLE with clk_sel=target and counter=SETTLE_WAIT-1. clk_sel changes only on this transition or on an abort.
- SETTLE: lasts SETTLE_WAIT cycles. When counter=0, enter GATE_ON.
- GATE_ON: lasts one cycle. clk_gate_en=1, busy=0, and exactly one of sel_ack or sel_err pulses (sel_err if an abort occurred). Returns to IDLE next cycle.
- Normal switch latency: clk_sel changes at T+GATE_WAIT+1. clk_gate_en=1 and sel_ack occur at T+GATE_WAIT+SETTLE_WAIT+1.
- Abort: if clk_valid[target]=0 is sampled in GATE_OFF or SETTLE, the next cycle applies clk_sel=prev_sel, target=prev_sel, an abort flag, and re-entry to SETTLE with the full count. Further aborts are not evaluated after one has occurred.
- sel_req while busy=1 is silently dropped, with no ack or err.
- sel_ack and sel_err are never high in the same cycle. clk_gate_en is never 1 in a cycle where clk_sel differs from its previous-cycle value.
- clk_valid of the current source is not monitored in IDLE. That is the owner's responsibility.

Test Plan:
(Configuration: NUM_CLOCKS=4, GATE_WAIT=4, SETTLE_WAIT=8, RESET_SEL=0.)
1. Reset: hold rst_n=0 for 3 cycles, then release -> clk_sel=0, clk_gate_en=0, busy=1 during reset; clk_gate_en=1 and busy=0 exactly 8 cycles after release; no sel_ack.
2. Switch with clk_valid=4'b1111, sel_req_id=2 at T -> clk_gate_en=0 and busy=1 at T+1; clk_sel=2 at T+5; clk_gate_en=1, sel_ack=1, busy=0 at T+13.
3. Same-source and invalid requests:
   - sel_req_id=0 while clk_sel=0 -> sel_ack at T+1, clk_gate_en stays 1.
   - sel_req_id=3 with clk_valid[3]=0 -> sel_err at T+1, clk_sel unchanged.
   - NUM_CLOCKS=3 build, sel_req_id=3 -> sel_err at T+1.
4. Request while busy: sel_req_id=1 at T+6 during the scenario-2 switch -> ignored; only the single sel_ack at T+13 occurs; clk_sel=2.
5. Abort: switch 0->2 at T, clk_valid[2] driven low in cycle T+7 -> clk_sel=0 at T+8; clk_gate_en=1 and sel_err=1 at T+16; no sel_ack.
6. Mid-sequence reset: rst_n=0 at T+3 of a switch -> reset values on the next edge; the post-reset sequence then repeats scenario 1.
